// File: rtl/oled_pkg.sv
// Shared opcodes, decoder state type and argument-count lookup for the OLED SPI sink.
package oled_pkg;

   localparam logic [7:0] OP_CONTRAST    = 8'h81;
   localparam logic [7:0] OP_CHARGE_PUMP = 8'h8D;
   localparam logic [7:0] OP_MUX_RATIO   = 8'hA8;
   localparam logic [7:0] OP_DISP_OFFSET = 8'hD3;
   localparam logic [7:0] OP_CLK_DIV     = 8'hD5;
   localparam logic [7:0] OP_PRECHARGE   = 8'hD9;
   localparam logic [7:0] OP_COM_PINS    = 8'hDA;
   localparam logic [7:0] OP_VCOMH       = 8'hDB;
   localparam logic [7:0] OP_ADDR_MODE   = 8'h20;
   localparam logic [7:0] OP_COL_RANGE   = 8'h21;
   localparam logic [7:0] OP_PAGE_RANGE  = 8'h22;
   localparam logic [7:0] OP_DISP_OFF    = 8'hAE;
   localparam logic [7:0] OP_DISP_ON     = 8'hAF;

   typedef enum logic [1:0] {
      ST_CMD  = 2'd0,
      ST_ARG1 = 2'd1,
      ST_ARG2 = 2'd2
   } dec_state_e;

   // Number of argument bytes that follow a command opcode.
   function automatic logic [1:0] arg_count(input logic [7:0] op);
      case (op)
         OP_CONTRAST, OP_CHARGE_PUMP, OP_MUX_RATIO, OP_DISP_OFFSET, OP_CLK_DIV,
         OP_PRECHARGE, OP_COM_PINS, OP_VCOMH, OP_ADDR_MODE: arg_count = 2'd1;
         OP_COL_RANGE, OP_PAGE_RANGE:                       arg_count = 2'd2;
         default:                                           arg_count = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/oled_spi_sink_if.sv
// SPI pins, framebuffer read port and decoded-byte status of the OLED SPI sink.
interface oled_spi_sink_if #(parameter int AW = 9) ();

   logic          CS;
   logic          SCLK;
   logic          SDIN;
   logic          DC;
   logic [AW-1:0] RD_ADDR;
   logic [7:0]    RD_DATA;
   logic          BYTE_VALID;
   logic [7:0]    BYTE_DATA;
   logic          BYTE_IS_DATA;
   logic          DISP_ON;
   logic          FRAME_DONE;

   modport master (
      output CS, SCLK, SDIN, DC, RD_ADDR,
      input  RD_DATA, BYTE_VALID, BYTE_DATA, BYTE_IS_DATA, DISP_ON, FRAME_DONE
   );

   modport slave (
      input  CS, SCLK, SDIN, DC, RD_ADDR,
      output RD_DATA, BYTE_VALID, BYTE_DATA, BYTE_IS_DATA, DISP_ON, FRAME_DONE
   );

endinterface

// File: rtl/oled_spi_deser.sv
// Synchronises the SPI pins into CLK and assembles MSB-first bytes; a byte pulses byte_vld
// SYNC_STAGES+1 cycles after its 8th SCLK rise. CS high drops any partial byte.
module oled_spi_deser #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       cs,
   input  logic       sclk,
   input  logic       sdin,
   input  logic       dc,
   output logic       byte_vld,
   output logic [7:0] byte_dat,
   output logic       byte_is_data
);

   // Each stage carries {cs, sclk, sdin, dc}.
   logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
   logic       sclk_prev_q, sclk_prev_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [6:0] shift_q, shift_d;
   logic       byte_vld_q, byte_vld_d;
   logic [7:0] byte_dat_q, byte_dat_d;
   logic       byte_is_data_q, byte_is_data_d;
   logic       s_cs, s_sclk, s_sdin, s_dc, sclk_rise;

   always_comb begin
      sync_d[0] = {cs, sclk, sdin, dc};
      for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
      {s_cs, s_sclk, s_sdin, s_dc} = sync_q[SYNC_STAGES-1];
      sclk_rise      = s_sclk & ~sclk_prev_q;
      sclk_prev_d    = s_sclk;
      bit_cnt_d      = bit_cnt_q;
      shift_d        = shift_q;
      byte_vld_d     = 1'b0;
      byte_dat_d     = byte_dat_q;
      byte_is_data_d = byte_is_data_q;
      if (s_cs) begin
         bit_cnt_d = '0;
         shift_d   = '0;
      end else if (sclk_rise) begin
         shift_d   = {shift_q[5:0], s_sdin};
         bit_cnt_d = bit_cnt_q + 3'd1;
         if (bit_cnt_q == 3'd7) begin
            byte_vld_d     = 1'b1;
            byte_dat_d     = {shift_q, s_sdin};
            byte_is_data_d = s_dc;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync_q         <= '0;
         sclk_prev_q    <= 1'b0;
         bit_cnt_q      <= '0;
         shift_q        <= '0;
         byte_vld_q     <= 1'b0;
         byte_dat_q     <= '0;
         byte_is_data_q <= 1'b0;
      end else begin
         sync_q         <= sync_d;
         sclk_prev_q    <= sclk_prev_d;
         bit_cnt_q      <= bit_cnt_d;
         shift_q        <= shift_d;
         byte_vld_q     <= byte_vld_d;
         byte_dat_q     <= byte_dat_d;
         byte_is_data_q <= byte_is_data_d;
      end
   end

   assign byte_vld     = byte_vld_q;
   assign byte_dat     = byte_dat_q;
   assign byte_is_data = byte_is_data_q;

endmodule

// File: rtl/oled_spi_sink.sv
// SPI display sink: command decode, page/column tracking and, with OLED_SINK_FB_EN, a framebuffer.
// Data lands in memory one cycle after BYTE_VALID; the SPI side has no backpressure.
module oled_spi_sink
   import oled_pkg::*;
#(
   parameter int COLS        = 128,
   parameter int PAGES       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic            CLK,
   input  logic            RST_N,
   oled_spi_sink_if.slave  bus
);

   localparam int PW = (PAGES > 1) ? $clog2(PAGES) : 1;

   logic          byte_vld, byte_is_data;
   logic [7:0]    byte_dat;
   dec_state_e    state_q, state_d;
   logic [PW-1:0] page_q, page_d;
   logic [6:0]    col_q, col_d, col_eff;
   logic          disp_on_q, disp_on_d;
   logic          wr_pend_q, wr_pend_d;
   logic          last_col;

   oled_spi_deser #(.SYNC_STAGES(SYNC_STAGES)) u_deser (
      .CLK          (CLK),
      .RST_N        (RST_N),
      .cs           (bus.CS),
      .sclk         (bus.SCLK),
      .sdin         (bus.SDIN),
      .dc           (bus.DC),
      .byte_vld     (byte_vld),
      .byte_dat     (byte_dat),
      .byte_is_data (byte_is_data)
   );

   always_comb begin
      col_eff   = 7'(int'(col_q) % COLS);
      last_col  = (int'(col_eff) == COLS - 1);
      state_d   = state_q;
      page_d    = page_q;
      col_d     = col_q;
      disp_on_d = disp_on_q;
      wr_pend_d = byte_vld & byte_is_data;
      if (wr_pend_q) col_d = last_col ? 7'd0 : col_eff + 7'd1;
      // Data bytes never reach the decoder; argument bytes are swallowed unseen.
      if (byte_vld && !byte_is_data) begin
         case (state_q)
            ST_ARG2: state_d = ST_ARG1;
            ST_ARG1: state_d = ST_CMD;
            ST_CMD: begin
               case (arg_count(byte_dat))
                  2'd1:    state_d = ST_ARG1;
                  2'd2:    state_d = ST_ARG2;
                  default: state_d = ST_CMD;
               endcase
               if (byte_dat[7:3] == 5'b10110) page_d = PW'(int'(byte_dat[2:0]) % PAGES);
               else if (byte_dat[7:4] == 4'h0) col_d[3:0] = byte_dat[3:0];
               else if (byte_dat[7:4] == 4'h1) col_d[6:4] = byte_dat[2:0];
               else if (byte_dat == OP_DISP_ON) disp_on_d = 1'b1;
               else if (byte_dat == OP_DISP_OFF) disp_on_d = 1'b0;
            end
            default: state_d = ST_CMD;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= ST_CMD;
         page_q    <= '0;
         col_q     <= '0;
         disp_on_q <= 1'b0;
         wr_pend_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         page_q    <= page_d;
         col_q     <= col_d;
         disp_on_q <= disp_on_d;
         wr_pend_q <= wr_pend_d;
      end
   end

   assign bus.BYTE_VALID   = byte_vld;
   assign bus.BYTE_DATA    = byte_dat;
   assign bus.BYTE_IS_DATA = byte_is_data;
   assign bus.DISP_ON      = disp_on_q;

`ifdef OLED_SINK_FB_EN
   localparam int DEPTH = COLS * PAGES;
   localparam int AW    = $clog2(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [7:0]    rd_data_q, rd_data_d;
   logic [7:0]    wr_dat_q, wr_dat_d;
   logic          frame_done_q, frame_done_d;
   logic [AW-1:0] wr_addr;

   always_comb begin
      wr_dat_d     = (byte_vld && byte_is_data) ? byte_dat : wr_dat_q;
      wr_addr      = AW'(int'(page_q) * COLS + int'(col_eff));
      frame_done_d = wr_pend_q && (int'(page_q) == PAGES - 1) && last_col;
      rd_data_d    = mem[bus.RD_ADDR];
   end

   // Contents survive reset; a read colliding with a write sees the old byte.
   always_ff @(posedge CLK) begin
      if (wr_pend_q) mem[wr_addr] <= wr_dat_q;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rd_data_q    <= '0;
         wr_dat_q     <= '0;
         frame_done_q <= 1'b0;
      end else begin
         rd_data_q    <= rd_data_d;
         wr_dat_q     <= wr_dat_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign bus.RD_DATA    = rd_data_q;
   assign bus.FRAME_DONE = frame_done_q;
`else
   logic unused_rd_addr;
   assign unused_rd_addr = ^bus.RD_ADDR;
   assign bus.RD_DATA    = '0;
   assign bus.FRAME_DONE = 1'b0;
`endif

endmodule

// File: doc/oled_spi_sink.md
OLED_SPI_SINK -- requirements
Module: oled_spi_sink

Interface
REQ-001 Parameter COLS, default 128, columns per page.
REQ-002 Parameter PAGES, default 4, pages (8-pixel rows) held.
REQ-003 Parameter SYNC_STAGES, default 2, synchroniser depth on CS/SCLK/SDIN/DC.
REQ-004 CLK  in  1  system clock; sole clock.
REQ-005 RST_N  in  1  reset, asynchronous, active-low.
REQ-006 CS  in  1  SPI chip select, active-low.
REQ-007 SCLK  in  1  SPI clock, asynchronous to CLK, at most CLK/4.
REQ-008 SDIN  in  1  SPI serial data, MSB first.
REQ-009 DC  in  1  0 = command byte, 1 = display data byte.
REQ-010 RD_ADDR  in  log2(COLS*PAGES)  framebuffer read address, page*COLS+col.
REQ-011 RD_DATA  out  8  framebuffer readback byte.
REQ-012 BYTE_VALID  out  1  one-cycle pulse per received byte.
REQ-013 BYTE_DATA  out  8  last received byte.
REQ-014 BYTE_IS_DATA  out  1  DC value latched with that byte.
REQ-015 DISP_ON  out  1  display-on state.
REQ-016 FRAME_DONE  out  1  one-cycle pulse on write to page PAGES-1, column COLS-1.

Function
REQ-017 CS, SCLK, SDIN and DC SHALL each pass through SYNC_STAGES flops before use.
REQ-018 Bits SHALL be sampled on synchronised SCLK rising edges only while synchronised CS is low, shifted MSB first.
REQ-019 On the 8th bit, BYTE_DATA and BYTE_IS_DATA (DC sampled on that edge) SHALL update and BYTE_VALID SHALL pulse, within SYNC_STAGES+2 CLK cycles of the SCLK edge.
REQ-020 CS deasserting mid-byte SHALL discard the partial byte, clear the bit counter and produce no BYTE_VALID.
REQ-021 Decoder FSM states SHALL be CMD, ARG1, ARG2; bytes with DC=1 bypass the FSM and never change its state.
REQ-022 In CMD: 0x81, 0x8D, 0xA8, 0xD3, 0xD5, 0xD9, 0xDA, 0xDB, 0x20 -> ARG1; 0x21, 0x22 -> ARG2; all else stays in CMD.
REQ-023 ARG2 -> ARG1 -> CMD on each command byte; argument values are consumed and ignored.
REQ-024 In CMD: 0xB0-0xB7 set page = low bits mod PAGES; 0x00-0x0F set column[3:0]; 0x10-0x1F set column[6:4] from bits 2:0; 0xAF sets DISP_ON; 0xAE clears it; other codes have no effect.
REQ-025 A data byte SHALL write framebuffer[page][col] the cycle after BYTE_VALID, then col increments; col COLS-1 wraps to 0, page unchanged (page addressing mode).
REQ-026 A column set beyond COLS-1 SHALL clamp writes by wrapping col mod COLS.
REQ-027 RD_DATA SHALL be registered, valid one cycle after RD_ADDR; a same-cycle read and write of one address returns the old byte.
REQ-028 CS high SHALL NOT reset page, col, FSM state or DISP_ON.

Reset
REQ-029 RST_N low SHALL asynchronously clear all outputs, bit counter, shift register, page, col and synchronisers, and set FSM to CMD.
REQ-030 Framebuffer contents SHALL NOT be cleared by reset; reset mid-byte discards the byte.

Configuration
REQ-031 With macro OLED_SINK_FB_EN defined, the framebuffer, REQ-025..027 and FRAME_DONE are built.
REQ-032 Without OLED_SINK_FB_EN, no memory is built, RD_DATA and FRAME_DONE are constant 0, and all other behaviour is unchanged.

Structure
REQ-033 Package oled_pkg SHALL hold command opcode constants, the decoder FSM state typedef and the argument-count lookup.
REQ-034 Sub-module oled_spi_deser SHALL hold synchronisers, edge detect and byte assembly; decode and framebuffer live in oled_spi_sink.

Verification
REQ-035 Send cmd 0xAF -> BYTE_VALID once, BYTE_DATA=0xAF, BYTE_IS_DATA=0, DISP_ON=1.
REQ-036 Send cmds 0xB2,0x05,0x13 then data 0x3C -> RD_ADDR=2*128+0x35 reads 0x3C.
REQ-037 Send cmd 0x81 then 0xAE -> 0xAE is consumed as an argument, DISP_ON unchanged; next 0xAE clears DISP_ON.
REQ-038 Raise CS after 5 bits, then send full byte 0xA5 -> exactly one BYTE_VALID, BYTE_DATA=0xA5.
REQ-039 Page 3, column 127, data 0x11 then 0x22 -> FRAME_DONE pulses once; 0x22 lands at page 3 column 0.
REQ-040 Pull RST_N low mid-byte -> outputs 0 immediately, FSM CMD, previously written framebuffer bytes still readable.
